// File: rtl/serial_lane_mux_if.sv
// Bus bundle for serial_lane_mux: lane inputs, selection controls and framed serial output.
// The lane_mask signal exists only when LANE_MASK_EN is defined.
interface serial_lane_mux_if #(
  parameter int LANES = 4
) ();
  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0] din;
  logic             din_valid;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic             sel_load;
  logic             dout;
  logic             dout_valid;
  logic [SELW-1:0]  dout_lane;
  logic             frame_start;
  logic             frame_end;
  logic             sel_err;
`ifdef LANE_MASK_EN
  logic [LANES-1:0] lane_mask;

  modport master (
    output din, din_valid, mode, sel, sel_load, lane_mask,
    input  dout, dout_valid, dout_lane, frame_start, frame_end, sel_err
  );
  modport slave (
    input  din, din_valid, mode, sel, sel_load, lane_mask,
    output dout, dout_valid, dout_lane, frame_start, frame_end, sel_err
  );
`else
  modport master (
    output din, din_valid, mode, sel, sel_load,
    input  dout, dout_valid, dout_lane, frame_start, frame_end, sel_err
  );
  modport slave (
    input  din, din_valid, mode, sel, sel_load,
    output dout, dout_valid, dout_lane, frame_start, frame_end, sel_err
  );
`endif
endinterface

// File: rtl/serial_lane_mux.sv
// Frame-aligned N-lane serial mux: lane switches (manual or round-robin) only at frame boundaries.
// Optional LANE_MASK_EN adds a per-lane disable mask honoured by scan, load and queued selection.
module serial_lane_mux #(
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_lane_mux_if.slave bus
);
  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PADW = 2 ** SELW;
  localparam logic [CW-1:0] LAST    = CW'(FRAME_LEN - 1);
  localparam logic [SELW:0] LANES_W = (SELW + 1)'(LANES);

  logic [SELW-1:0] active_q, active_d;
  logic [SELW-1:0] pend_lane_q, pend_lane_d;
  logic            pend_vld_q, pend_vld_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic [SELW-1:0] dout_lane_q, dout_lane_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_end_q, frame_end_d;
  logic            sel_err_q, sel_err_d;

  logic [LANES-1:0] lane_dis;
  logic [PADW-1:0]  dis_pad;
  logic [SELW-1:0]  scan_next;
  logic [SELW-1:0]  cand;
  logic             scan_found;
  logic             wrap;
  logic             sel_ok;

`ifdef LANE_MASK_EN
  assign lane_dis = bus.lane_mask;
`else
  assign lane_dis = '0;
`endif
  // Padded to the full index range so an out-of-range sel can still be looked up safely.
  assign dis_pad = PADW'(lane_dis);
  assign wrap    = bus.din_valid && (bit_cnt_q == LAST);
  assign sel_ok  = ({1'b0, bus.sel} < LANES_W) && !dis_pad[bus.sel];

  // First eligible lane after active in circular order; holds when none is eligible.
  always_comb begin
    scan_next  = active_q;
    scan_found = 1'b0;
    cand       = '0;
    for (int k = 1; k < LANES; k++) begin
      cand = SELW'((int'(active_q) + k) % LANES);
      if (!scan_found && !lane_dis[cand]) begin
        scan_next  = cand;
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    active_d      = active_q;
    pend_lane_d   = pend_lane_q;
    pend_vld_d    = pend_vld_q;
    bit_cnt_d     = bit_cnt_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    dout_lane_d   = dout_lane_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    sel_err_d     = 1'b0;

    if (bus.din_valid) begin
      dout_d        = bus.din[active_q];
      dout_valid_d  = 1'b1;
      dout_lane_d   = active_q;
      frame_start_d = (bit_cnt_q == '0);
      frame_end_d   = (bit_cnt_q == LAST);
      bit_cnt_d     = wrap ? '0 : bit_cnt_q + 1'b1;
    end

    // A queued lane that became ineligible is dropped; scan/hold applies instead.
    if (wrap) begin
      pend_vld_d = 1'b0;
      if (pend_vld_q && !dis_pad[pend_lane_q]) begin
        active_d = pend_lane_q;
      end else if (bus.mode) begin
        active_d = scan_next;
      end
    end

    // Loads on a wrap cycle land in the queue after the wrap has consumed the old entry.
    if (bus.sel_load) begin
      if (!sel_ok) begin
        sel_err_d = 1'b1;
      end else if ((bit_cnt_q == '0) && !bus.din_valid) begin
        active_d   = bus.sel;
        pend_vld_d = 1'b0;
      end else begin
        pend_lane_d = bus.sel;
        pend_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= '0;
      pend_lane_q   <= '0;
      pend_vld_q    <= 1'b0;
      bit_cnt_q     <= '0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_lane_q   <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      active_q      <= active_d;
      pend_lane_q   <= pend_lane_d;
      pend_vld_q    <= pend_vld_d;
      bit_cnt_q     <= bit_cnt_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dout_lane_q   <= dout_lane_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_lane   = dout_lane_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.sel_err     = sel_err_q;
endmodule
